pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 16-bit five-stage CPU pipeline. It drives the load enables and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards:

- load-use data hazards;
- taken-branch control hazards;
- multi-cycle data-memory accesses (ready handshake with timeout).

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- REG_ADDR_W, 4, register-file address width
- MEM_TIMEOUT, 16, maximum cycles spent in MEM_WAIT before fault (≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_rs1  in  REG_ADDR_W  source register 1 of instruction in ID
- id_rs2  in  REG_ADDR_W  source register 2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_W  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a memory load
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables
- if_id_flush, id_ex_flush  out  1 each  load a NOP (ni=0, wbs=0) instead of data
- mem_wb_bubble  out  1  MEM/WB captures a bubble: wbs and ni forced 0
- mem_fault  out  1  sticky memory-timeout flag
- stall_cycles  out  16  count of cycles with pc_en=0, saturates at 16'hFFFF

## Operation
- States: RUN, MEM_WAIT, FAULT. Control outputs are combinational from state and inputs. wait_cnt, stall_cycles and mem_fault are registered.
- Memory stall condition: mem_stall = mem_req & ~mem_ready.
- Load-use condition: lu = ex_is_load & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Register 0 never causes a hazard.
- Priority: mem_stall > ex_branch_taken > lu.

RUN:
- mem_stall:
  - pc_en and if_id_en, id_ex_en, ex_mem_en = 0;
  - mem_wb_en=1 with mem_wb_bubble=1;
  - next state MEM_WAIT, wait_cnt←0.
- ex_branch_taken:
  - all enables 1;
  - if_id_flush=1 and id_ex_flush=1.
- lu:
  - pc_en=0, if_id_en=0;
  - id_ex_en=1 with id_ex_flush=1;
  - ex_mem_en=1, mem_wb_en=1.
- Otherwise all enables 1, all flush/bubble 0.

MEM_WAIT:
- mem_ready=1: this cycle is evaluated exactly as a RUN cycle with mem_stall=0, so branch and lu still apply. Next state RUN.
- mem_ready=0 and wait_cnt<MEM_TIMEOUT-1: same outputs as the RUN mem_stall case, wait_cnt+1.
- mem_ready=0 and wait_cnt==MEM_TIMEOUT-1: stall outputs this cycle. Next state FAULT, mem_fault←1.

FAULT:
- pc_en and all stage enables 0 except mem_wb_en=1, mem_wb_bubble=1.
- Held until rst. mem_fault stays 1.

stall_cycles increments on every non-reset cycle with pc_en=0, and saturates.

## Timing
- While rst=1:
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0;
  - mem_wb_en=1, mem_wb_bubble=1;
  - flushes 0.
- First clock edge with rst=1:
  - state←RUN, wait_cnt←0, stall_cycles←0, mem_fault←0.
- rst mid-MEM_WAIT or in FAULT returns to RUN on that edge. No partial access is retained.
- Load-use costs exactly 1 stall cycle. No state is needed: the next cycle the load is in MEM, so lu deasserts.
- Branch costs 2 squashed instructions and 0 stall cycles.
- Memory access with mem_req at cycle N and mem_ready first high at cycle N+k (k≥1):
  - pc_en=0 for cycles N..N+k-1;
  - the pipeline advances at N+k;
  - state is RUN at N+k+1.
- Timeout: mem_req at N with mem_ready never rising:
  - MEM_WAIT occupies N+1..N+MEM_TIMEOUT;
  - FAULT is entered at N+MEM_TIMEOUT+1, with mem_fault=1 from that cycle.
- mem_ready with mem_req=0 is ignored in RUN.

## Test plan
- Reset: hold rst 3 cycles.
  - During reset: pc_en=0, mem_wb_bubble=1.
  - After release (no hazards): all enables 1, stall_cycles=0, mem_fault=0.
- Load-use: ex_is_load=1, ex_rd=3, id_rs2=3, id_uses_rs2=1.
  - Cycle response: pc_en=0, if_id_en=0, id_ex_flush=1.
  - stall_cycles=1 the next cycle.
  - Repeat with ex_rd=0: no stall.
- Branch vs load-use: ex_branch_taken=1 with the lu condition also true.
  - Required: if_id_flush=1, id_ex_flush=1, pc_en=1.
  - stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1.
  - 4 cycles with pc_en=0, mem_wb_bubble=1.
  - 5th cycle: all enables 1, mem_wb_bubble=0.
  - stall_cycles=4.
- Timeout: MEM_TIMEOUT=16, mem_ready held 0.
  - FAULT entered after 17 stalled cycles; mem_fault=1 and stays 1.
  - rst clears it, then normal RUN.
- Saturation and mid-stall reset:
  - Preload via 65 540 stalled cycles: stall_cycles=16'hFFFF and holds.
  - rst asserted during MEM_WAIT: next cycle RUN, counter 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the five-stage pipeline. It resolves
// load-use hazards, taken branches and multi-cycle data-memory accesses,
// and it guards memory accesses with a timeout.
// Control outputs are combinational from the state and the inputs.
// The wait counter, the stall-cycle counter and the fault flag are registered.
module pipeline_stall_controller #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_bubble,
  output logic                  mem_fault,
  output logic [15:0]           stall_cycles
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic            mem_fault_q, mem_fault_d;

  logic            mem_stall_s;
  logic            lu_s;
  logic            hold_s;   // freeze front end, drain a bubble into MEM/WB

  assign mem_stall_s = mem_req & ~mem_ready;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign lu_s = ex_is_load & (ex_rd != {REG_ADDR_W{1'b0}}) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                 (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Next-state logic: sequence memory waits, detect timeout, and apply reset.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_fault_d = mem_fault_q;
    hold_s      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_s) begin
          hold_s     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = {WCW{1'b0}};
        end else begin
          hold_s = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        // The completing cycle behaves as an ordinary RUN cycle.
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          hold_s      = 1'b1;
          state_d     = ST_FAULT;
          mem_fault_d = 1'b1;
        end else begin
          hold_s     = 1'b1;
          wait_cnt_d = wait_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
        end
      end
      ST_FAULT: begin
        hold_s = 1'b1;
      end
      default: begin
        hold_s  = 1'b1;
        state_d = ST_RUN;
      end
    endcase
    if (rst) begin
      hold_s      = 1'b1;
      state_d     = ST_RUN;
      wait_cnt_d  = {WCW{1'b0}};
      mem_fault_d = 1'b0;
    end else begin
      hold_s = hold_s;
    end
  end

  // Output decode: hold > branch squash > load-use bubble > free run.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (hold_s) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_comb begin
    if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, wait counter, stall counter and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= {WCW{1'b0}};
      stall_cnt_q <= 16'd0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  assign mem_fault    = mem_fault_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: a vector table for the
// single-cycle hazard cases plus sequences for memory wait, timeout,
// counter saturation and mid-wait reset. Expected values are queued when a
// cycle is driven and checked on the following falling edge.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [3:0] id_rs1 = 4'd0, id_rs2 = 4'd0, ex_rd = 4'd0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_is_load = 1'b0;
  logic       ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault;
  logic [15:0] stall_cycles;

  pipeline_stall_controller #(.REG_ADDR_W(4), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_fault(mem_fault),
    .stall_cycles(stall_cycles)
  );

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [7:0] C_RUN   = 8'b1111_1000;
  localparam logic [7:0] C_STALL = 8'b0000_1001;
  localparam logic [7:0] C_BR    = 8'b1111_1110;
  localparam logic [7:0] C_LU    = 8'b0011_1010;

  typedef struct {
    logic       r;
    logic [3:0] rs1, rs2;
    logic       u1, u2;
    logic [3:0] rd;
    logic       ld, br, mreq, mrdy;
    logic [7:0] ctl;
    logic       fault;
  } vec_t;

  typedef struct {
    int          id;
    logic [7:0]  ctl;
    logic [15:0] sc;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        chk_e;
  int          n_checks = 0;
  int          n_err = 0;
  int          step_id = 0;
  logic [15:0] exp_sc = 16'd0;
  logic [7:0]  ctl_s;
  vec_t        tbl[17];

  assign ctl_s = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, mem_wb_bubble};

  function automatic vec_t mk(input logic r, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic u1, input logic u2, input logic [3:0] rd,
                              input logic ld, input logic br, input logic mreq,
                              input logic mrdy, input logic [7:0] ctl, input logic fault);
    vec_t v;
    v.r = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.ctl = ctl; v.fault = fault;
    return v;
  endfunction

  function automatic vec_t memv(input logic r, input logic mreq, input logic mrdy,
                                input logic [7:0] ctl, input logic fault);
    return mk(r, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, mreq, mrdy, ctl, fault);
  endfunction

  // Drive one cycle; queue its expectation and advance the stall-counter model.
  task automatic cyc(input vec_t v, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.r; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; ex_branch_taken = v.br;
    mem_req = v.mreq; mem_ready = v.mrdy;
    if (chk) begin
      e.id = step_id; e.ctl = v.ctl; e.sc = exp_sc; e.fault = v.fault;
      exp_q.push_back(e);
    end
    step_id++;
    if (v.r) exp_sc = 16'd0;
    else if (!v.ctl[7] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
  endtask

  // Scoreboard: compare the oldest expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      chk_e = exp_q.pop_front();
      n_checks = n_checks + 3;
      if (ctl_s !== chk_e.ctl) begin
        n_err++;
        $display("FAIL ctl step %0d: got %b want %b", chk_e.id, ctl_s, chk_e.ctl);
      end
      if (stall_cycles !== chk_e.sc) begin
        n_err++;
        $display("FAIL stall_cycles step %0d: got %0d want %0d", chk_e.id, stall_cycles, chk_e.sc);
      end
      if (mem_fault !== chk_e.fault) begin
        n_err++;
        $display("FAIL mem_fault step %0d: got %b want %b", chk_e.id, mem_fault, chk_e.fault);
      end
    end
  end

  initial begin
    // r, rs1, rs2, u1, u2, rd, ld, br, mreq, mrdy, ctl, fault
    tbl[0]  = mk(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 1'b0);
    tbl[1]  = mk(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, C_STALL, 1'b0);
    tbl[2]  = mk(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL, 1'b0);
    tbl[3]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0);
    tbl[4]  = mk(1'b0, 4'd1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,    1'b0);
    tbl[5]  = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0);
    tbl[6]  = mk(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0);
    tbl[7]  = mk(1'b0, 4'd5, 4'd2, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,    1'b0);
    tbl[8]  = mk(1'b0, 4'd5, 4'd2, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0);
    tbl[9]  = mk(1'b0, 4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0);
    tbl[10] = mk(1'b0, 4'd7, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,    1'b0);
    tbl[11] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,    1'b0);
    tbl[12] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN,   1'b0);
    tbl[13] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,   1'b0);
    tbl[14] = mk(1'b0, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, C_STALL, 1'b0);
    tbl[15] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR,    1'b0);
    tbl[16] = mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,   1'b0);

    for (int i = 0; i < 17; i++) cyc(tbl[i], 1'b1);

    // Memory wait: 4 stalled cycles, then completion advances the pipeline.
    for (int i = 0; i < 4; i++) cyc(memv(1'b0, 1'b1, 1'b0, C_STALL, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b1, 1'b1, C_RUN, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b0, 1'b0, C_RUN, 1'b0), 1'b1);

    // Completion cycle still honours a load-use hazard.
    cyc(memv(1'b0, 1'b1, 1'b0, C_STALL, 1'b0), 1'b1);
    cyc(mk(1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, C_LU, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b0, 1'b0, C_RUN, 1'b0), 1'b1);

    // Timeout: 17 stalled cycles without fault, then FAULT with sticky flag.
    for (int i = 0; i < 17; i++) cyc(memv(1'b0, 1'b1, 1'b0, C_STALL, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b1, 1'b0, C_STALL, 1'b1), 1'b1);
    cyc(memv(1'b0, 1'b1, 1'b1, C_STALL, 1'b1), 1'b1);
    cyc(memv(1'b0, 1'b0, 1'b0, C_STALL, 1'b1), 1'b1);

    // Saturation: stay in FAULT long enough to pin the counter.
    for (int i = 0; i < 65540; i++) cyc(memv(1'b0, 1'b0, 1'b0, C_STALL, 1'b1), 1'b0);
    for (int i = 0; i < 3; i++) cyc(memv(1'b0, 1'b0, 1'b1, C_STALL, 1'b1), 1'b1);

    // Reset clears fault and counter, then normal running resumes.
    cyc(memv(1'b1, 1'b0, 1'b0, C_STALL, 1'b1), 1'b1);
    cyc(memv(1'b0, 1'b0, 1'b0, C_RUN, 1'b0), 1'b1);
    cyc(mk(1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LU, 1'b0), 1'b1);

    // Reset in the middle of a memory wait returns straight to RUN.
    cyc(memv(1'b0, 1'b1, 1'b0, C_STALL, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b1, 1'b0, C_STALL, 1'b0), 1'b1);
    cyc(memv(1'b1, 1'b1, 1'b0, C_STALL, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b0, 1'b0, C_RUN, 1'b0), 1'b1);
    cyc(memv(1'b0, 1'b0, 1'b0, C_RUN, 1'b0), 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
